// File: rtl/proc_pkg.sv
// ---------------------------------------------------------------------------
// proc_pkg
// Shared definitions for the simple 16-bit processor control unit.
//   - instruction geometry (IR_WIDTH, NUM_REGS, field slice positions)
//   - opcode constants
//   - time-step encoding T0..T3
//   - small field-extraction and classification helpers
// ---------------------------------------------------------------------------
package proc_pkg;

   localparam int IR_WIDTH = 9;
   localparam int NUM_REGS = 8;

   // Instruction format: III XXX YYY (opcode, Rx, Ry)
   localparam int OP_HI = 8;
   localparam int OP_LO = 6;
   localparam int RX_HI = 5;
   localparam int RX_LO = 3;
   localparam int RY_HI = 2;
   localparam int RY_LO = 0;

   // Opcodes; 100..111 are reserved and execute as nop
   localparam logic [2:0] OP_MV  = 3'b000;
   localparam logic [2:0] OP_MVI = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_SUB = 3'b011;

   // Time-step encoding
   localparam logic [1:0] T0 = 2'd0;
   localparam logic [1:0] T1 = 2'd1;
   localparam logic [1:0] T2 = 2'd2;
   localparam logic [1:0] T3 = 2'd3;

   function automatic logic [2:0] op_of(input logic [IR_WIDTH-1:0] ir);
      return ir[OP_HI:OP_LO];
   endfunction

   function automatic logic [2:0] rx_of(input logic [IR_WIDTH-1:0] ir);
      return ir[RX_HI:RX_LO];
   endfunction

   function automatic logic [2:0] ry_of(input logic [IR_WIDTH-1:0] ir);
      return ir[RY_HI:RY_LO];
   endfunction

   // add and sub are the only instructions that use T2/T3
   function automatic logic is_alu_op(input logic [2:0] op);
      return (op == OP_ADD) || (op == OP_SUB);
   endfunction

endpackage

// File: rtl/proc_control_unit_checker.sv
// ---------------------------------------------------------------------------
// proc_control_unit_checker
// Observes the control outputs and flags any violation of the bus and
// load-enable exclusivity rules, and any add_sub outside an ALU step.
//   clk, rst        : in  clock and asynchronous active-high reset
//   ir_in .. done   : in  the control unit outputs being watched
// ---------------------------------------------------------------------------
module proc_control_unit_checker
   import proc_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                ir_in,
   input  logic [NUM_REGS-1:0] r_in,
   input  logic [NUM_REGS-1:0] r_out,
   input  logic                g_out,
   input  logic                din_out,
   input  logic                a_in,
   input  logic                g_in,
   input  logic                add_sub,
   input  logic                done
);

   logic [3:0] bus_count;
   logic [3:0] rin_count;

   // Number of active bus drivers and register loads this cycle
   always_comb begin
      bus_count = 4'($countones({r_out, g_out, din_out}));
      rin_count = 4'($countones(r_in));
   end

   a_bus_one_hot: assert property (@(posedge clk) disable iff (rst)
      bus_count <= 4'd1);

   a_rin_one_hot: assert property (@(posedge clk) disable iff (rst)
      rin_count <= 4'd1);

   a_a_g_exclusive: assert property (@(posedge clk) disable iff (rst)
      !(a_in && g_in));

   // add_sub is only meaningful while G is being loaded
   a_add_sub_only_t2: assert property (@(posedge clk) disable iff (rst)
      add_sub |-> g_in);

   // A fetch and a completion never overlap in the same cycle
   a_no_fetch_on_done: assert property (@(posedge clk) disable iff (rst)
      !(ir_in && done));

endmodule

// File: rtl/proc_control_unit_dec3to8.sv
// ---------------------------------------------------------------------------
// dec3to8
// 3-bit index to 8-bit one-hot decoder with enable. Output is all zeros
// when en is low.
//   idx    : in  [2:0] selected bit position
//   en     : in        decoder enable
//   onehot : out [7:0] one-hot result
// ---------------------------------------------------------------------------
module dec3to8
   import proc_pkg::*;
(
   input  logic [2:0] idx,
   input  logic       en,
   output logic [7:0] onehot
);

   // One-hot decode of idx, gated by en
   always_comb begin
      onehot = 8'b0000_0000;
      if (en) begin
         onehot[idx] = 1'b1;
      end else begin
         onehot = 8'b0000_0000;
      end
   end

endmodule

// File: rtl/proc_control_unit.sv
// ---------------------------------------------------------------------------
// proc_control_unit
// Control FSM of the simple 16-bit processor. Decodes the instruction
// register and sequences time steps T0..T3, producing one-hot bus-source
// selects and register load enables for the datapath.
//   clk     : in         system clock, rising edge
//   rst     : in         asynchronous reset, active-high
//   run     : in         start request, sampled only in T0
//   ir      : in  [8:0]  instruction register contents (III XXX YYY)
//   ir_in   : out        IR load enable
//   r_in    : out [7:0]  per-register load enable
//   r_out   : out [7:0]  per-register bus-source select
//   g_out   : out        bus-source select for G
//   din_out : out        bus-source select for DIN
//   a_in    : out        A register load enable
//   g_in    : out        G register load enable
//   add_sub : out        ALU control, 0 = add, 1 = subtract
//   done    : out        one-cycle instruction-complete pulse
// Outputs are a combinational decode of (step, ir, run); loads take effect
// at the clock edge that ends the cycle.
// ---------------------------------------------------------------------------
module proc_control_unit
   import proc_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                run,
   input  logic [IR_WIDTH-1:0] ir,
   output logic                ir_in,
   output logic [NUM_REGS-1:0] r_in,
   output logic [NUM_REGS-1:0] r_out,
   output logic                g_out,
   output logic                din_out,
   output logic                a_in,
   output logic                g_in,
   output logic                add_sub,
   output logic                done
);

   logic [1:0] step;
   logic [1:0] step_next;

   logic [2:0] op;
   logic [2:0] rx;
   logic [2:0] ry;

   // Register-file select controls feeding the two decoders
   logic       rin_en;
   logic       rout_en;
   logic [2:0] rout_idx;

   assign op = op_of(ir);
   assign rx = ry_of(ir) == ry_of(ir) ? rx_of(ir) : 3'b000;
   assign ry = ry_of(ir);

   // Time-step register; reset returns to T0 immediately
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         step <= T0;
      end else begin
         step <= step_next;
      end
   end

   // Step decode: next step and all control strobes. While rst is high
   // every strobe is held at 0, so an aborted instruction never signals done
   // and T0 does not reflect run into ir_in during reset.
   always_comb begin
      step_next = T0;
      ir_in     = 1'b0;
      rin_en    = 1'b0;
      rout_en   = 1'b0;
      rout_idx  = 3'b000;
      g_out     = 1'b0;
      din_out   = 1'b0;
      a_in      = 1'b0;
      g_in      = 1'b0;
      add_sub   = 1'b0;
      done      = 1'b0;
      if (rst) begin
         step_next = T0;
      end else begin
         case (step)
            T0: begin
               ir_in     = run;
               step_next = run ? T1 : T0;
            end
            T1: begin
               case (op)
                  OP_MV: begin
                     rout_en   = 1'b1;
                     rout_idx  = ry;
                     rin_en    = 1'b1;
                     done      = 1'b1;
                     step_next = T0;
                  end
                  OP_MVI: begin
                     din_out   = 1'b1;
                     rin_en    = 1'b1;
                     done      = 1'b1;
                     step_next = T0;
                  end
                  OP_ADD, OP_SUB: begin
                     rout_en   = 1'b1;
                     rout_idx  = rx;
                     a_in      = 1'b1;
                     step_next = T2;
                  end
                  default: begin
                     // reserved opcodes complete as nop
                     done      = 1'b1;
                     step_next = T0;
                  end
               endcase
            end
            T2: begin
               // Only add/sub reach T2; guard anyway so a changed ir cannot
               // drive the bus from a non-ALU opcode.
               if (is_alu_op(op)) begin
                  rout_en   = 1'b1;
                  rout_idx  = ry;
                  g_in      = 1'b1;
                  add_sub   = (op == OP_SUB);
                  step_next = T3;
               end else begin
                  step_next = T0;
               end
            end
            T3: begin
               if (is_alu_op(op)) begin
                  g_out     = 1'b1;
                  rin_en    = 1'b1;
                  done      = 1'b1;
                  step_next = T0;
               end else begin
                  step_next = T0;
               end
            end
            default: begin
               step_next = T0;
            end
         endcase
      end
   end

   // Destination register load enable: always Rx when enabled
   dec3to8 u_dec_rin (
      .idx    (rx),
      .en     (rin_en),
      .onehot (r_in)
   );

   // Bus source register select: Rx in T1 of add/sub, Ry otherwise
   dec3to8 u_dec_rout (
      .idx    (rout_idx),
      .en     (rout_en),
      .onehot (r_out)
   );

endmodule

// File: tb/tb_proc_control_unit.sv
module tb_proc_control_unit;
   import proc_pkg::*;

   logic                clk;
   logic                rst;
   logic                run;
   logic [IR_WIDTH-1:0] ir;
   logic                ir_in;
   logic [NUM_REGS-1:0] r_in;
   logic [NUM_REGS-1:0] r_out;
   logic                g_out;
   logic                din_out;
   logic                a_in;
   logic                g_in;
   logic                add_sub;
   logic                done;

   int checks = 0;
   int errors = 0;

   proc_control_unit dut (
      .clk(clk), .rst(rst), .run(run), .ir(ir),
      .ir_in(ir_in), .r_in(r_in), .r_out(r_out), .g_out(g_out),
      .din_out(din_out), .a_in(a_in), .g_in(g_in),
      .add_sub(add_sub), .done(done)
   );

   proc_control_unit_checker u_chk (
      .clk(clk), .rst(rst), .ir_in(ir_in), .r_in(r_in), .r_out(r_out),
      .g_out(g_out), .din_out(din_out), .a_in(a_in), .g_in(g_in),
      .add_sub(add_sub), .done(done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Output bundle: {ir_in, r_in, r_out, g_out, din_out, a_in, g_in, add_sub, done}
   typedef struct {
      logic        rst;
      logic        run;
      logic [8:0]  ir;
      logic        e_ir_in;
      logic [7:0]  e_r_in;
      logic [7:0]  e_r_out;
      logic        e_g_out;
      logic        e_din_out;
      logic        e_a_in;
      logic        e_g_in;
      logic        e_add_sub;
      logic        e_done;
   } vec_t;

   localparam int NV = 27;
   vec_t vec [NV];

   function automatic logic [22:0] outs_now();
      return {ir_in, r_in, r_out, g_out, din_out, a_in, g_in, add_sub, done};
   endfunction

   task automatic check(input string name, input int idx,
                        input logic [22:0] act, input logic [22:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s[%0d] got %h want %h", name, idx, act, exp);
      end
   endtask

   task automatic check_bus(input string name, input int idx);
      int n;
      n = $countones({r_out, g_out, din_out});
      checks++;
      if (n > 1) begin
         errors++;
         $display("FAIL %s[%0d] bus selects active got %0d want <=1", name, idx, n);
      end
   endtask

   task automatic setv(input int i, input logic rs, input logic rn, input logic [8:0] iv,
                       input logic ii, input logic [7:0] ri, input logic [7:0] ro,
                       input logic go, input logic dn, input logic ai, input logic gi,
                       input logic as, input logic dd);
      vec[i] = '{rs, rn, iv, ii, ri, ro, go, dn, ai, gi, as, dd};
   endtask

   initial begin
      logic [8:0] MV25, MVI7, ADD13, SUB00, MV33, NOP, ADD33, RSV;
      MV25  = 9'b000_010_101;
      MVI7  = 9'b001_111_000;
      ADD13 = 9'b010_001_011;
      SUB00 = 9'b011_000_000;
      MV33  = 9'b000_011_011;
      NOP   = 9'b101_000_000;
      ADD33 = 9'b010_011_011;
      RSV   = 9'b111_111_111;

      //      i  rst run ir     ir_in r_in   r_out  gout din ain gin as done
      setv( 0, 1'b1, 1'b1, MV25,  1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      setv( 1, 1'b0, 1'b0, MV25,  1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      setv( 2, 1'b0, 1'b1, MV25,  1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      setv( 3, 1'b0, 1'b0, MV25,  1'b0, 8'h04, 8'h20, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      setv( 4, 1'b0, 1'b1, MVI7,  1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      setv( 5, 1'b0, 1'b0, MVI7,  1'b0, 8'h80, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      setv( 6, 1'b0, 1'b1, ADD13, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      setv( 7, 1'b0, 1'b1, ADD13, 1'b0, 8'h00, 8'h02, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      setv( 8, 1'b0, 1'b1, ADD13, 1'b0, 8'h00, 8'h08, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      setv( 9, 1'b0, 1'b0, ADD13, 1'b0, 8'h02, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      setv(10, 1'b0, 1'b1, SUB00, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      setv(11, 1'b0, 1'b1, SUB00, 1'b0, 8'h00, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      setv(12, 1'b0, 1'b1, SUB00, 1'b0, 8'h00, 8'h01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      setv(13, 1'b0, 1'b1, SUB00, 1'b0, 8'h01, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      setv(14, 1'b0, 1'b1, MV33,  1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      setv(15, 1'b0, 1'b1, MV33,  1'b0, 8'h08, 8'h08, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      setv(16, 1'b0, 1'b1, NOP,   1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      setv(17, 1'b0, 1'b1, NOP,   1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      setv(18, 1'b0, 1'b0, NOP,   1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      setv(19, 1'b0, 1'b0, NOP,   1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      setv(20, 1'b0, 1'b1, ADD33, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      setv(21, 1'b0, 1'b0, ADD33, 1'b0, 8'h00, 8'h08, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      setv(22, 1'b0, 1'b0, ADD33, 1'b0, 8'h00, 8'h08, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      setv(23, 1'b0, 1'b0, ADD33, 1'b0, 8'h08, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      setv(24, 1'b0, 1'b1, RSV,   1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      setv(25, 1'b0, 1'b0, RSV,   1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      setv(26, 1'b0, 1'b0, RSV,   1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      rst = 1'b1;
      run = 1'b0;
      ir  = 9'b0;
      @(posedge clk);
      #1;

      // Table: inputs driven just after posedge, outputs sampled on negedge
      for (int i = 0; i < NV; i++) begin
         rst = vec[i].rst;
         run = vec[i].run;
         ir  = vec[i].ir;
         @(negedge clk);
         check("vec", i, outs_now(),
               {vec[i].e_ir_in, vec[i].e_r_in, vec[i].e_r_out, vec[i].e_g_out,
                vec[i].e_din_out, vec[i].e_a_in, vec[i].e_g_in,
                vec[i].e_add_sub, vec[i].e_done});
         check_bus("vec_bus", i);
         @(posedge clk);
         #1;
      end

      // Reset mid-T2 of add R1,R3 aborts asynchronously
      run = 1'b1;
      ir  = ADD13;
      @(negedge clk);
      check("rst_seq_t0", 0, outs_now(), {1'b1, 8'h00, 8'h00, 6'b000000});
      @(posedge clk);
      #1;
      run = 1'b0;
      @(posedge clk);
      #1;
      check("rst_seq_t2", 0, outs_now(), {1'b0, 8'h00, 8'h08, 6'b000100});
      #2;
      rst = 1'b1;
      #1;
      check("rst_async_zero", 0, outs_now(), 23'h0);
      run = 1'b1;
      #1;
      check("rst_run_masked", 0, outs_now(), 23'h0);
      @(posedge clk);
      #1;
      check("rst_held", 0, outs_now(), 23'h0);
      run = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_release", 0, outs_now(), 23'h0);
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1;
         check("idle_t0", k, outs_now(), 23'h0);
      end
      // Still in T0 (not T3 or T1): run gives a fetch, no done/g_out
      run = 1'b1;
      #1;
      check("post_rst_fetch", 0, outs_now(), {1'b1, 8'h00, 8'h00, 6'b000000});
      @(posedge clk);
      #1;
      run = 1'b0;
      check("post_rst_t1", 0, outs_now(), {1'b0, 8'h00, 8'h02, 6'b001000});

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Watchdog so the run always terminates
   initial begin
      #20000;
      $display("FAIL watchdog timeout");
      errors++;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1);
   end

endmodule
